count_seq_checker: RTL and testbench

- Sequence monitor placed directly downstream of the 3-bit up/down counter (counter_d / counter_jk).
- Samples the counter's count and mode on every clock and checks that each step is the legal +1 or -1 modulo 2^WIDTH.
- Locks after a run of good steps, flags and counts illegal steps, and pulses on wrap-around.
- Used on the lab bench and as a self-check stage behind the D and JK counter variants.

---
 rtl/count_seq_checker.sv | 172 +++++++++++++++++
 tb/tb_count_seq_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Sequence monitor for an up/down counter: checks every step is +1/-1 mod 2^WIDTH,
// locks after LOCK_N good steps, counts illegal steps. Optional: COUNT_SEQ_CHECKER_LAST_BAD_EN.
module count_seq_checker #(
    parameter int WIDTH  = 3,
    parameter int ERR_W  = 4,
    parameter int LOCK_N = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_cnt_reset,
    input  logic             i_clr_err,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic             o_wrap_pulse,
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
    output logic [WIDTH-1:0] o_last_bad,
    output logic [WIDTH-1:0] o_last_exp,
`endif
    output logic [ERR_W-1:0] o_err_count
);

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1'b1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_prev_count;
    logic             r_prev_mode;
    logic [3:0]       r_good_cnt;
    logic [3:0]       w_next_good;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_wrap_pulse;
    logic [ERR_W-1:0] r_err_count;
    logic [ERR_W-1:0] w_next_err_count;
    logic [WIDTH-1:0] w_exp;
    logic             w_good;
    logic             w_wrap_step;
    logic             w_err_det;
    logic             w_wrap_det;

    // Expected value uses the direction sampled at the previous edge.
    always_comb begin
        if (r_prev_mode) begin
            w_exp       = r_prev_count - CNT_ONE;
            w_wrap_step = (r_prev_count == CNT_ZERO);
        end else begin
            w_exp       = r_prev_count + CNT_ONE;
            w_wrap_step = (r_prev_count == CNT_MAX);
        end
        w_good = (i_count == w_exp);
    end

    // Next-state logic: acquisition, lock and error detection.
    always_comb begin
        w_next_state = r_state;
        w_next_good  = r_good_cnt;
        w_err_det    = 1'b0;
        w_wrap_det   = 1'b0;
        if (i_cnt_reset) begin
            w_next_state = ST_IDLE;
            w_next_good  = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_ACQ;
                    w_next_good  = 4'd0;
                end
                ST_ACQ: begin
                    if (w_good) begin
                        w_wrap_det = w_wrap_step;
                        if ((r_good_cnt + 4'd1) >= LOCK_TGT) begin
                            w_next_state = ST_LOCKED;
                            w_next_good  = LOCK_TGT;
                        end else begin
                            w_next_good = r_good_cnt + 4'd1;
                        end
                    end else begin
                        w_next_good = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_good) begin
                        w_wrap_det = w_wrap_step;
                    end else begin
                        w_err_det    = 1'b1;
                        w_next_good  = 4'd0;
                        w_next_state = ST_ACQ;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_good  = 4'd0;
                end
            endcase
        end
    end

    // Saturating error counter; clear has priority over a coincident error.
    always_comb begin
        if (i_clr_err) begin
            w_next_err_count = {ERR_W{1'b0}};
        end else if (w_err_det && (r_err_count != ERR_MAX)) begin
            w_next_err_count = r_err_count + ERR_ONE;
        end else begin
            w_next_err_count = r_err_count;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_prev_count <= {WIDTH{1'b0}};
            r_prev_mode  <= 1'b0;
            r_good_cnt   <= 4'd0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_err_count  <= {ERR_W{1'b0}};
        end else begin
            r_state      <= w_next_state;
            r_prev_count <= i_count;
            r_prev_mode  <= i_mode;
            r_good_cnt   <= w_next_good;
            r_locked     <= (w_next_state == ST_LOCKED);
            r_err_pulse  <= w_err_det;
            r_wrap_pulse <= w_wrap_det;
            r_err_count  <= w_next_err_count;
        end
    end

`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
    logic [WIDTH-1:0] r_last_bad;
    logic [WIDTH-1:0] r_last_exp;

    // Capture the offending and expected values of the latest locked error.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_last_bad <= {WIDTH{1'b0}};
            r_last_exp <= {WIDTH{1'b0}};
        end else if (w_err_det) begin
            r_last_bad <= i_count;
            r_last_exp <= w_exp;
        end else begin
            r_last_bad <= r_last_bad;
            r_last_exp <= r_last_exp;
        end
    end

    assign o_last_bad = r_last_bad;
    assign o_last_exp = r_last_exp;
`endif

    assign o_locked     = r_locked;
    assign o_err_pulse  = r_err_pulse;
    assign o_wrap_pulse = r_wrap_pulse;
    assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed-vector bench for count_seq_checker (WIDTH=3, ERR_W=4, LOCK_N=2).
module tb_count_seq_checker;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [2:0] count;
    logic       cnt_reset;
    logic       clr_err;
    logic       locked;
    logic       err_pulse;
    logic       wrap_pulse;
    logic [3:0] err_count;
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
    logic [2:0] last_bad;
    logic [2:0] last_exp;
`endif

    int n_vec;
    int n_err;
    logic [2:0] c;
    int exp_ec;

    count_seq_checker #(.WIDTH(3), .ERR_W(4), .LOCK_N(2)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_mode       (mode),
        .i_count      (count),
        .i_cnt_reset  (cnt_reset),
        .i_clr_err    (clr_err),
        .o_locked     (locked),
        .o_err_pulse  (err_pulse),
        .o_wrap_pulse (wrap_pulse),
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
        .o_last_bad   (last_bad),
        .o_last_exp   (last_exp),
`endif
        .o_err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one vector, clock it in and settle just after the edge.
    task automatic tick(input logic [2:0] cv, input logic mv, input logic cr, input logic ce);
        count     = cv;
        mode      = mv;
        cnt_reset = cr;
        clr_err   = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [2:0] cv);
        tick(cv, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        count     = 3'd0;
        cnt_reset = 1'b0;
        clr_err   = 1'b0;
        #1;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_err_count", {28'd0, err_count}, 32'd0);
        chk("rst_pulses", {30'd0, err_pulse, wrap_pulse}, 32'd0);
        #11 rst_n = 1'b1;

        // Acquisition: IDLE, then two good steps lock.
        step(3'd0); chk("acq_e1_locked", {31'd0, locked}, 32'd0);
        step(3'd1); chk("acq_e2_locked", {31'd0, locked}, 32'd0);
        step(3'd2); chk("acq_e3_locked", {31'd0, locked}, 32'd1);
        for (int i = 3; i < 8; i++) step(3'(i));
        chk("pre_wrap", {31'd0, wrap_pulse}, 32'd0);
        step(3'd0); chk("wrap_up", {31'd0, wrap_pulse}, 32'd1);
        step(3'd1); chk("wrap_up_drop", {31'd0, wrap_pulse}, 32'd0);
        chk("up_err_count", {28'd0, err_count}, 32'd0);

        // Direction change takes effect on the step after it is sampled.
        step(3'd2); step(3'd3); step(3'd4); step(3'd5);
        tick(3'd6, 1'b1, 1'b0, 1'b0);
        chk("dir_6_err", {31'd0, err_pulse}, 32'd0);
        for (int i = 5; i >= 0; i--) begin
            tick(3'(i), 1'b1, 1'b0, 1'b0);
            chk("down_err", {31'd0, err_pulse}, 32'd0);
            chk("down_locked", {31'd0, locked}, 32'd1);
        end
        chk("down_nowrap", {31'd0, wrap_pulse}, 32'd0);
        tick(3'd7, 1'b1, 1'b0, 1'b0); chk("wrap_down", {31'd0, wrap_pulse}, 32'd1);
        tick(3'd6, 1'b0, 1'b0, 1'b0); chk("wrap_down_drop", {31'd0, wrap_pulse}, 32'd0);
        chk("dir_back_err", {31'd0, err_pulse}, 32'd0);

        // Single illegal step 3 -> 5 while locked.
        step(3'd7); step(3'd0); step(3'd1); step(3'd2); step(3'd3);
        step(3'd5);
        chk("bad_pulse", {31'd0, err_pulse}, 32'd1);
        chk("bad_count", {28'd0, err_count}, 32'd1);
        chk("bad_unlock", {31'd0, locked}, 32'd0);
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
        chk("last_bad", {29'd0, last_bad}, 32'd5);
        chk("last_exp", {29'd0, last_exp}, 32'd4);
`endif
        step(3'd6);
        chk("bad_pulse_drop", {31'd0, err_pulse}, 32'd0);
        chk("relock_1", {31'd0, locked}, 32'd0);
        step(3'd7);
        chk("relock_2", {31'd0, locked}, 32'd1);
        c = 3'd7;

        // 20 isolated errors with relock between: saturate at 15.
        for (int i = 0; i < 20; i++) begin
            c = c + 3'd3;
            step(c);
            exp_ec = (i + 2 > 15) ? 15 : i + 2;
            chk("sat_pulse", {31'd0, err_pulse}, 32'd1);
            chk("sat_count", {28'd0, err_count}, 32'(exp_ec));
            c = c + 3'd1; step(c);
            c = c + 3'd1; step(c);
            chk("sat_relock", {31'd0, locked}, 32'd1);
        end

        // Clear coinciding with an error: clear wins, pulse still fires.
        c = c + 3'd3;
        tick(c, 1'b0, 1'b0, 1'b1);
        chk("clr_count", {28'd0, err_count}, 32'd0);
        chk("clr_pulse", {31'd0, err_pulse}, 32'd1);
        c = c + 3'd1; step(c);
        c = c + 3'd1; step(c);
        for (int i = 0; i < 3; i++) begin
            c = c + 3'd2;
            step(c);
            c = c + 3'd1; step(c);
            c = c + 3'd1; step(c);
        end
        chk("three_errs", {28'd0, err_count}, 32'd3);
        chk("three_relock", {31'd0, locked}, 32'd1);

        // Counter reset for two cycles; count jumps to 0.
        tick(3'd0, 1'b0, 1'b1, 1'b0);
        chk("crst_locked", {31'd0, locked}, 32'd0);
        chk("crst_pulse", {31'd0, err_pulse}, 32'd0);
        tick(3'd0, 1'b0, 1'b1, 1'b0);
        chk("crst_count", {28'd0, err_count}, 32'd3);
        step(3'd1); chk("crst_idle", {31'd0, locked}, 32'd0);
        chk("crst_idle_pulse", {31'd0, err_pulse}, 32'd0);
        step(3'd2); chk("crst_acq", {31'd0, locked}, 32'd0);
        step(3'd3); chk("crst_relock", {31'd0, locked}, 32'd1);
        chk("crst_count_kept", {28'd0, err_count}, 32'd3);

        // Asynchronous reset between edges while wrap_pulse is high.
        step(3'd4); step(3'd5); step(3'd6); step(3'd7); step(3'd0);
        chk("pre_arst_wrap", {31'd0, wrap_pulse}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked", {31'd0, locked}, 32'd0);
        chk("arst_count", {28'd0, err_count}, 32'd0);
        chk("arst_pulses", {30'd0, err_pulse, wrap_pulse}, 32'd0);
`ifdef COUNT_SEQ_CHECKER_LAST_BAD_EN
        chk("arst_last_bad", {29'd0, last_bad}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Monitoring restarts from IDLE.
        step(3'd4); chk("restart_e1", {31'd0, locked}, 32'd0);
        step(3'd5); chk("restart_e2", {31'd0, locked}, 32'd0);
        step(3'd6); chk("restart_e3", {31'd0, locked}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
